// File: rtl/restoring_divider.sv
// Restoring divider: 8-bit unsigned x / y, one quotient bit per cycle.
// A request is accepted in IDLE, takes 8 RUN cycles, then a single DONE cycle.
// Divide-by-zero skips RUN and completes with q=8'hFF, r=x, dz=1.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          request, sampled only in IDLE
//   x, y           dividend, divisor (unsigned, 8 bits)
//   q, r, dz       registered quotient, remainder, divide-by-zero flag
//   busy, done     state==RUN, state==DONE (registered)
module restoring_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] q,
  output logic [7:0] r,
  output logic       busy,
  output logic       done,
  output logic       dz
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  xr, xr_n;
  logic [W-1:0]  yr, yr_n;
  logic [W:0]    pr, pr_n;
  logic [W-1:0]  qr, qr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  q_n, r_n;
  logic          dz_n;

  logic [W:0]    shifted, diff, pr_it;
  logic          qbit;
  logic [W-1:0]  qr_it;

  // One restoring step: shift in the next dividend bit, trial-subtract y.
  always_comb begin
    shifted = {pr[W-1:0], xr[W-1]};
    diff    = shifted + ~{1'b0, yr} + (W+1)'(1);
    qbit    = ~diff[W];
    pr_it   = qbit ? diff : shifted;
    qr_it   = {qr[W-2:0], qbit};
  end

  // Next-state and datapath control.
  always_comb begin
    state_n = state;
    xr_n    = xr;
    yr_n    = yr;
    pr_n    = pr;
    qr_n    = qr;
    cnt_n   = cnt;
    q_n     = q;
    r_n     = r;
    dz_n    = dz;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (y != '0) begin
            xr_n    = x;
            yr_n    = y;
            pr_n    = '0;
            qr_n    = '0;
            cnt_n   = CW'(W);
            state_n = RUN;
          end else begin
            q_n     = '1;
            r_n     = x;
            dz_n    = 1'b1;
            state_n = DONE;
          end
        end
      end
      RUN: begin
        xr_n  = {xr[W-2:0], 1'b0};
        pr_n  = pr_it;
        qr_n  = qr_it;
        cnt_n = cnt - CW'(1);
        // Last iteration publishes the results directly from this step.
        if (cnt == CW'(1)) begin
          q_n     = qr_it;
          r_n     = pr_it[W-1:0];
          dz_n    = 1'b0;
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; busy/done track the next state so they
  // equal the state decode every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      xr    <= '0;
      yr    <= '0;
      pr    <= '0;
      qr    <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      xr    <= xr_n;
      yr    <= yr_n;
      pr    <= pr_n;
      qr    <= qr_n;
      cnt   <= cnt_n;
      q     <= q_n;
      r     <= r_n;
      dz    <= dz_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
    end
  end

endmodule
